output_layer_seq_ctrl: RTL

- Sequencer for the 10-neuron output layer.
- Captures the parallel result vector of the preceding hidden layer and streams it serially, one word per cycle, into the output layer's shared valid/data input.
- Collects the ten neuron results and selects the winning neuron by a sequential argmax.
- Reports the recognised digit with a one-cycle valid pulse. It sits between the last hidden layer and the top-level result interface.

---
 rtl/output_layer_seq_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/output_layer_seq_ctrl.sv
// Output-layer sequencer: captures the previous layer's result vector,
// streams it word by word into the output layer, collects the neuron
// results, picks the winner by sequential signed argmax and reports it.
module output_layer_seq_ctrl #(
    parameter int prevNeurons   = 10,
    parameter int neurons       = 10,
    parameter int dataWidth     = 16,
    parameter int idxWidth      = 4,
    parameter int timeoutCycles = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [prevNeurons-1:0]           prev_valid,
    input  logic [prevNeurons*dataWidth-1:0] prev_data,
    output logic                             lay_in_valid,
    output logic [dataWidth-1:0]             lay_in_data,
    input  logic [neurons-1:0]               lay_out_valid,
    input  logic [neurons*dataWidth-1:0]     lay_out_data,
    output logic                             digit_valid,
    output logic [idxWidth-1:0]              digit,
    output logic [dataWidth-1:0]             digit_score,
    output logic                             busy,
    output logic                             overrun_err,
    output logic                             timeout_err
);

    localparam int SCW = (prevNeurons > 1) ? $clog2(prevNeurons) : 1;
    localparam int WCW = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
    localparam logic [SCW-1:0]      STREAM_LAST = SCW'(prevNeurons - 1);
    localparam logic [WCW-1:0]      WAIT_LAST   = WCW'(timeoutCycles - 1);
    localparam logic [idxWidth-1:0] ARG_LAST    = idxWidth'(neurons - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT,
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [dataWidth-1:0]  buf_q [prevNeurons];
    logic [dataWidth-1:0]  res_q [neurons];
    logic [neurons-1:0]    flags_q;
    logic [SCW-1:0]        stream_cnt_q;
    logic [WCW-1:0]        wait_cnt_q;
    logic [idxWidth-1:0]   arg_k_q;
    logic [idxWidth-1:0]   best_idx_q;
    logic [dataWidth-1:0]  best_val_q;

    logic                  capture;
    logic                  complete;
    logic                  take_k;
    logic [idxWidth-1:0]   cand_idx;
    logic [dataWidth-1:0]  cand_val;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and the argmax candidate for the current compare step.
    always_comb begin
        state_d  = state_q;
        capture  = &prev_valid;
        // Bits arriving this cycle count towards completion.
        complete = &(flags_q | lay_out_valid);
        // Index 0 is taken unconditionally so a result that arrived on the
        // WAIT exit edge is never compared against a stale best value.
        take_k   = (arg_k_q == '0) ||
                   ($signed(res_q[arg_k_q]) > $signed(best_val_q));
        cand_idx = take_k ? arg_k_q : best_idx_q;
        cand_val = take_k ? res_q[arg_k_q] : best_val_q;
        unique case (state_q)
            S_IDLE:   if (capture) state_d = S_STREAM;
            S_STREAM: if (stream_cnt_q == STREAM_LAST) state_d = S_WAIT;
            S_WAIT: begin
                if (complete)                     state_d = S_ARGMAX;
                else if (wait_cnt_q == WAIT_LAST) state_d = S_IDLE;
            end
            S_ARGMAX: if (arg_k_q == ARG_LAST) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Buffers, counters, collected-valid flags and the running argmax.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < prevNeurons; i++) buf_q[i] <= '0;
            for (int unsigned j = 0; j < neurons; j++)     res_q[j] <= '0;
            flags_q      <= '0;
            stream_cnt_q <= '0;
            wait_cnt_q   <= '0;
            arg_k_q      <= '0;
            best_idx_q   <= '0;
            best_val_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (capture) begin
                        for (int unsigned i = 0; i < prevNeurons; i++)
                            buf_q[i] <= prev_data[i*dataWidth +: dataWidth];
                        stream_cnt_q <= '0;
                        wait_cnt_q   <= '0;
                        flags_q      <= '0;
                    end
                end
                S_STREAM: stream_cnt_q <= stream_cnt_q + 1'b1;
                S_WAIT: begin
                    for (int unsigned j = 0; j < neurons; j++)
                        if (lay_out_valid[j])
                            res_q[j] <= lay_out_data[j*dataWidth +: dataWidth];
                    flags_q    <= flags_q | lay_out_valid;
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                    arg_k_q    <= '0;
                end
                S_ARGMAX: begin
                    best_idx_q <= cand_idx;
                    best_val_q <= cand_val;
                    arg_k_q    <= arg_k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; digit/score load on the final compare so they
    // become visible together with the digit_valid pulse in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lay_in_valid <= 1'b0;
            lay_in_data  <= '0;
            digit_valid  <= 1'b0;
            digit        <= '0;
            digit_score  <= '0;
            busy         <= 1'b0;
            overrun_err  <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            lay_in_valid <= (state_q == S_STREAM);
            lay_in_data  <= (state_q == S_STREAM) ? buf_q[stream_cnt_q] : '0;
            busy         <= (state_d != S_IDLE);
            overrun_err  <= capture && (state_q != S_IDLE);
            timeout_err  <= (state_q == S_WAIT) && !complete && (wait_cnt_q == WAIT_LAST);
            digit_valid  <= (state_q == S_ARGMAX) && (state_d == S_DONE);
            if ((state_q == S_ARGMAX) && (state_d == S_DONE)) begin
                digit       <= cand_idx;
                digit_score <= cand_val;
            end
        end
    end

endmodule
